// File: rtl/tetris_pkg.sv
// Shared Tetris playfield constants: grid size, lock-sequence states, line-clear
// score table and the grid-to-pixel mapping used by the renderer.
package tetris_pkg;

  localparam int GRID_W = 10;
  localparam int GRID_H = 20;

  typedef enum logic [2:0] {
    IDLE,
    LOCK,
    SCAN,
    SHIFT,
    DONE
  } state_t;

  // Points per lock, indexed by the number of rows cleared (0..4)
  localparam logic [4:0][3:0] SCORE_TAB = {4'd8, 4'd5, 4'd3, 4'd1, 4'd0};

  localparam int CELL_PX = 20;
  localparam int X_OFF   = 111;
  localparam int Y_OFF   = 21;

endpackage

// File: rtl/board_collide.sv
// Combinational collision test of the four falling-piece cells against the
// settled board; grid walls count as occupied, rows below the grid always collide.
module board_collide #(
  parameter int GRID_W = tetris_pkg::GRID_W,
  parameter int GRID_H = tetris_pkg::GRID_H
) (
  input  logic [3:0][9:0]               xs_i,
  input  logic [3:0][9:0]               ys_i,
  input  logic [GRID_H-1:0][GRID_W-1:0] board_i,
  output logic                          collide_down_o,
  output logic                          collide_left_o,
  output logic                          collide_right_o
);

  localparam int RW = $clog2(GRID_H);
  localparam int CW = $clog2(GRID_W);

  function automatic logic cell_at(input logic [GRID_H-1:0][GRID_W-1:0] b,
                                   input logic [9:0] y, input logic [9:0] x);
    if (y < 10'(GRID_H) && x < 10'(GRID_W)) return b[y[RW-1:0]][x[CW-1:0]];
    return 1'b0;
  endfunction

  always_comb begin
    collide_down_o  = 1'b0;
    collide_left_o  = 1'b0;
    collide_right_o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ys_i[i] >= 10'(GRID_H)) begin
        collide_down_o  = 1'b1;
        collide_left_o  = 1'b1;
        collide_right_o = 1'b1;
      end else begin
        if (ys_i[i] >= 10'(GRID_H - 1) || cell_at(board_i, ys_i[i] + 10'd1, xs_i[i]))
          collide_down_o = 1'b1;
        if (xs_i[i] == 10'd0 || cell_at(board_i, ys_i[i], xs_i[i] - 10'd1))
          collide_left_o = 1'b1;
        if (xs_i[i] >= 10'(GRID_W - 1) || cell_at(board_i, ys_i[i], xs_i[i] + 10'd1))
          collide_right_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/playfield_board.sv
// Settled Tetris playfield: locks the falling piece in, clears full rows by
// shifting the rows above down, keeps score/game-over and serves a render read port.
module playfield_board #(
  parameter int GRID_W  = tetris_pkg::GRID_W,
  parameter int GRID_H  = tetris_pkg::GRID_H,
  parameter int SCORE_W = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               new_game,
  input  logic [9:0]         x0,
  input  logic [9:0]         x1,
  input  logic [9:0]         x2,
  input  logic [9:0]         x3,
  input  logic [9:0]         y0,
  input  logic [9:0]         y1,
  input  logic [9:0]         y2,
  input  logic [9:0]         y3,
  input  logic               lock_req,
  output logic               busy,
  output logic               lock_done,
  output logic [2:0]         lines_cleared,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               oob,
  output logic               collide_down,
  output logic               collide_left,
  output logic               collide_right,
  input  logic [4:0]         rd_row,
  input  logic [3:0]         rd_col,
  output logic               rd_cell
);

  import tetris_pkg::*;

  localparam int RW  = $clog2(GRID_H);
  localparam int CW  = $clog2(GRID_W);
  localparam int SW1 = SCORE_W + 1;

  state_t                         state_q;
  logic [GRID_H-1:0][GRID_W-1:0]  board_q;
  logic [GRID_H-1:0][GRID_W-1:0]  board_d;
  logic [RW-1:0]                  row_q;
  logic [RW-1:0]                  ptr_q;
  logic [2:0]                     cnt_q;
  logic                           lock_done_q;
  logic [2:0]                     lines_q;
  logic [SCORE_W-1:0]             score_q;
  logic                           game_over_q;
  logic                           oob_q;
  logic                           oob_d;
  logic                           rd_cell_q;
  logic [3:0][9:0]                xs;
  logic [3:0][9:0]                ys;

  assign xs = {x3, x2, x1, x0};
  assign ys = {y3, y2, y1, y0};

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [3:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + SW1'(b);
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  // Piece merged into the board; out-of-range cells are dropped and flagged
  always_comb begin
    board_d = board_q;
    oob_d   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (xs[i] < 10'(GRID_W) && ys[i] < 10'(GRID_H))
        board_d[ys[i][RW-1:0]][xs[i][CW-1:0]] = 1'b1;
      else
        oob_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n || new_game) begin
      state_q     <= IDLE;
      board_q     <= '0;
      row_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      lock_done_q <= 1'b0;
      lines_q     <= '0;
      score_q     <= '0;
      game_over_q <= 1'b0;
      oob_q       <= 1'b0;
      rd_cell_q   <= 1'b0;
    end else begin
      lock_done_q <= 1'b0;
      oob_q       <= 1'b0;
      rd_cell_q   <= (rd_row < 5'(GRID_H) && rd_col < 4'(GRID_W)) ? board_q[rd_row][rd_col] : 1'b0;
      case (state_q)
        IDLE: if (lock_req) state_q <= LOCK;
        LOCK: begin
          board_q <= board_d;
          oob_q   <= oob_d;
          row_q   <= RW'(GRID_H - 1);
          cnt_q   <= '0;
          state_q <= SCAN;
        end
        SCAN: begin
          if (&board_q[row_q]) begin
            cnt_q   <= cnt_q + 3'd1;
            ptr_q   <= row_q;
            state_q <= SHIFT;
          end else if (row_q == '0) begin
            state_q <= DONE;
          end else begin
            row_q <= row_q - RW'(1);
          end
        end
        // One row per cycle; the scan row is re-examined once the top is refilled
        SHIFT: begin
          if (ptr_q != '0) begin
            board_q[ptr_q] <= board_q[ptr_q - RW'(1)];
            ptr_q          <= ptr_q - RW'(1);
          end else begin
            board_q[0] <= '0;
            state_q    <= SCAN;
          end
        end
        DONE: begin
          lock_done_q <= 1'b1;
          lines_q     <= cnt_q;
          score_q     <= sat_add(score_q, SCORE_TAB[cnt_q]);
          game_over_q <= game_over_q | (|board_q[0]);
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  board_collide #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_collide (
    .xs_i            (xs),
    .ys_i            (ys),
    .board_i         (board_q),
    .collide_down_o  (collide_down),
    .collide_left_o  (collide_left),
    .collide_right_o (collide_right)
  );

  assign busy          = (state_q != IDLE);
  assign lock_done     = lock_done_q;
  assign lines_cleared = lines_q;
  assign score         = score_q;
  assign game_over     = game_over_q;
  assign oob           = oob_q;
  assign rd_cell       = rd_cell_q;

endmodule

// File: tb/tb_playfield_board.sv
// Directed bench for playfield_board: a table of lock vectors with hand-computed
// latency/score/probe results, plus hand sequences for collisions, game over and abort.
module tb_playfield_board;

  logic        Clk = 1'b0;
  logic        Reset_n, new_game, lock_req;
  logic [9:0]  x0, x1, x2, x3, y0, y1, y2, y3;
  logic        busy, lock_done, game_over, oob;
  logic [2:0]  lines_cleared;
  logic [15:0] score;
  logic        collide_down, collide_left, collide_right;
  logic [4:0]  rd_row;
  logic [3:0]  rd_col;
  logic        rd_cell;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  playfield_board #(.GRID_W(10), .GRID_H(20), .SCORE_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .new_game(new_game),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .lock_req(lock_req), .busy(busy), .lock_done(lock_done),
    .lines_cleared(lines_cleared), .score(score), .game_over(game_over), .oob(oob),
    .collide_down(collide_down), .collide_left(collide_left), .collide_right(collide_right),
    .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell)
  );

  typedef struct {
    logic [3:0][9:0] xs;
    logic [3:0][9:0] ys;
    int lat, lines, score, oob, down;
    int r1, c1, v1, r2, c2, v2;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(int ax0, int ay0, int ax1, int ay1, int ax2, int ay2,
                              int ax3, int ay3, int lat, int lines, int sc, int ob,
                              int r1, int c1, int v1, int r2, int c2, int v2);
    vec_t v;
    v.xs = {10'(ax3), 10'(ax2), 10'(ax1), 10'(ax0)};
    v.ys = {10'(ay3), 10'(ay2), 10'(ay1), 10'(ay0)};
    v.lat = lat; v.lines = lines; v.score = sc; v.oob = ob; v.down = 1;
    v.r1 = r1; v.c1 = c1; v.v1 = v1; v.r2 = r2; v.c2 = c2; v.v2 = v2;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_piece(input logic [3:0][9:0] xs, input logic [3:0][9:0] ys);
    x0 = xs[0]; x1 = xs[1]; x2 = xs[2]; x3 = xs[3];
    y0 = ys[0]; y1 = ys[1]; y2 = ys[2]; y3 = ys[3];
  endtask

  task automatic do_lock(input logic [3:0][9:0] xs, input logic [3:0][9:0] ys,
                         output int lat, output int oob_seen);
    @(negedge Clk);
    set_piece(xs, ys);
    lock_req = 1'b1;
    @(posedge Clk);
    #1 lock_req = 1'b0;
    chk("busy_after_accept", busy, 1);
    lat = -1;
    oob_seen = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge Clk);
      #1;
      if (oob) oob_seen = 1;
      if (lock_done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic read_cell(input int r, input int c, output int v);
    @(negedge Clk);
    rd_row = 5'(r);
    rd_col = 4'(c);
    @(posedge Clk);
    #1 v = int'(rd_cell);
  endtask

  task automatic count_cells(output int n);
    int v;
    n = 0;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) begin
        read_cell(r, c, v);
        n += v;
      end
  endtask

  task automatic probe_collide(input int x, input int y, input int ed, input int el,
                               input int er, input string tag);
    @(negedge Clk);
    set_piece({4{10'(x)}}, {4{10'(y)}});
    #1;
    chk({"down_", tag}, int'(collide_down), ed);
    chk({"left_", tag}, int'(collide_left), el);
    chk({"right_", tag}, int'(collide_right), er);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int lat, os, v, n, seen;

    vecs[0]  = mk(4,18, 5,18, 4,19, 5,19,  22,0,0,0, 18,4,1, 19,5,1);
    vecs[1]  = mk(0,19, 1,19, 2,19, 3,19,  22,0,0,0, 19,0,1, 19,3,1);
    vecs[2]  = mk(6,19, 7,19, 8,19, 9,19,  43,1,1,0, 19,4,1, 18,4,0);
    vecs[3]  = mk(0,19, 1,19, 2,19, 3,19,  22,0,1,0, 19,3,1, 19,9,0);
    vecs[4]  = mk(6,19, 7,19, 8,19, 0,18,  22,0,1,0, 19,8,1, 18,0,1);
    vecs[5]  = mk(1,18, 2,18, 3,18, 4,18,  22,0,1,0, 18,4,1, 18,9,0);
    vecs[6]  = mk(5,18, 6,18, 7,18, 8,18,  22,0,1,0, 18,8,1, 17,0,0);
    vecs[7]  = mk(0,17, 1,17, 2,17, 3,17,  22,0,1,0, 17,3,1, 16,0,0);
    vecs[8]  = mk(4,17, 5,17, 6,17, 7,17,  22,0,1,0, 17,7,1, 17,8,0);
    vecs[9]  = mk(8,17, 0,16, 1,16, 2,16,  22,0,1,0, 16,2,1, 17,8,1);
    vecs[10] = mk(3,16, 4,16, 5,16, 6,16,  22,0,1,0, 16,6,1, 16,7,0);
    vecs[11] = mk(7,16, 8,16, 8,16, 8,16,  22,0,1,0, 16,8,1, 16,9,0);
    vecs[12] = mk(9,16, 9,17, 9,18, 9,19, 106,4,9,0, 19,0,0, 16,3,0);
    vecs[13] = mk(0,19, 1,19, 2,19, 10,19, 22,0,9,1, 19,2,1, 19,3,0);

    Reset_n = 1'b0; new_game = 1'b0; lock_req = 1'b0;
    rd_row = '0; rd_col = '0;
    set_piece('0, '0);
    repeat (3) @(posedge Clk);
    @(negedge Clk) Reset_n = 1'b1;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_lock_done", int'(lock_done), 0);
    chk("reset_score", int'(score), 0);
    chk("reset_game_over", int'(game_over), 0);
    chk("reset_lines", int'(lines_cleared), 0);
    chk("reset_oob", int'(oob), 0);
    count_cells(n);
    chk("reset_cells_set", n, 0);

    for (int i = 0; i < 14; i++) begin
      do_lock(vecs[i].xs, vecs[i].ys, lat, os);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_lines", i), int'(lines_cleared), vecs[i].lines);
      chk($sformatf("v%0d_score", i), int'(score), vecs[i].score);
      chk($sformatf("v%0d_oob", i), os, vecs[i].oob);
      chk($sformatf("v%0d_busy_done", i), int'(busy), 0);
      chk($sformatf("v%0d_game_over", i), int'(game_over), 0);
      chk($sformatf("v%0d_collide_down", i), int'(collide_down), vecs[i].down);
      read_cell(vecs[i].r1, vecs[i].c1, v);
      chk($sformatf("v%0d_probe1", i), v, vecs[i].v1);
      read_cell(vecs[i].r2, vecs[i].c2, v);
      chk($sformatf("v%0d_probe2", i), v, vecs[i].v2);
    end

    // Board now holds row 19 columns 0..2 only
    probe_collide(5, 10, 0, 0, 0, "open");
    probe_collide(3, 19, 1, 1, 0, "floor_left");
    probe_collide(9, 5, 0, 0, 1, "right_wall");
    probe_collide(0, 5, 0, 1, 0, "left_wall");
    probe_collide(2, 18, 1, 0, 0, "stack");
    probe_collide(4, 20, 1, 1, 1, "below_grid");
    read_cell(25, 3, v);
    chk("read_row_oor", v, 0);
    read_cell(19, 12, v);
    chk("read_col_oor", v, 0);

    @(negedge Clk) new_game = 1'b1;
    @(posedge Clk);
    #1 new_game = 1'b0;
    chk("newgame_score", int'(score), 0);
    count_cells(n);
    chk("newgame_cells_set", n, 0);

    for (int k = 0; k < 5; k++) begin
      int b;
      b = 16 - 4 * k;
      do_lock({10'd0, 10'd0, 10'd0, 10'd0},
              {10'(b + 3), 10'(b + 2), 10'(b + 1), 10'(b)}, lat, os);
      chk($sformatf("col%0d_latency", k), lat, 22);
      chk($sformatf("col%0d_game_over", k), int'(game_over), (k == 4) ? 1 : 0);
    end
    read_cell(0, 0, v);
    chk("col_top_cell", v, 1);

    // Abort a lock mid-SCAN with new_game
    @(negedge Clk);
    set_piece({10'd8, 10'd7, 10'd6, 10'd5}, {10'd19, 10'd19, 10'd19, 10'd19});
    lock_req = 1'b1;
    @(posedge Clk);
    #1 lock_req = 1'b0;
    repeat (5) @(posedge Clk);
    #1 chk("abort_busy_before", int'(busy), 1);
    @(negedge Clk) new_game = 1'b1;
    @(posedge Clk);
    #1 new_game = 1'b0;
    chk("abort_busy_after", int'(busy), 0);
    seen = 0;
    for (int c = 0; c < 150; c++) begin
      @(posedge Clk);
      #1 if (lock_done) seen = 1;
    end
    chk("abort_no_lock_done", seen, 0);
    chk("abort_game_over", int'(game_over), 0);
    chk("abort_score", int'(score), 0);
    count_cells(n);
    chk("abort_cells_set", n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/playfield_board.md
# playfield_board

Stores the settled 10×20 Tetris playfield and consumes the falling piece's four grid coordinates from the piece-mover. On a lock request it writes the piece into the board, scans for and clears full rows, updates score, and flags game over. It also feeds collision flags back to the mover and serves a registered cell-read port to the VGA color mapper.

## Interface
Parameters:
- GRID_W, 10, playfield columns.
- GRID_H, 20, playfield rows; row 0 is the top.
- SCORE_W, 16, score width; the score saturates at its maximum value.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  reset; synchronous, active-low.
- new_game  in  1  clears the board, score and game_over in one cycle.
- x0..x3  in  10 each  piece cell columns, in grid units.
- y0..y3  in  10 each  piece cell rows, in grid units.
- lock_req  in  1  request to write the current piece into the board.
- busy  out  1  high in every state except IDLE.
- lock_done  out  1  one-cycle pulse when a lock sequence completes.
- lines_cleared  out  3  rows cleared by the last lock (0..4); valid from lock_done.
- score  out  SCORE_W  accumulated score.
- game_over  out  1  sticky flag.
- oob  out  1  one-cycle pulse when any piece cell was out of range during LOCK.
- collide_down, collide_left, collide_right  out  1 each  combinational collision flags for the current piece.
- rd_row  in  5  render read row.
- rd_col  in  4  render read column.
- rd_cell  out  1  occupancy of (rd_row, rd_col); 1-cycle latency.

## Operation
- Board storage: GRID_H registers, each GRID_W bits wide.
- Reset (Reset_n=0 at a Clk edge): board all 0; state IDLE; every output 0.
- new_game: takes priority over all FSM activity and has the same effect as reset.
- IDLE:
  - lock_req=1 → LOCK.
  - lock_req is ignored in every other state; no queueing.
- LOCK (1 cycle):
  - Sets board[y_i][x_i] for each cell i with x_i<GRID_W and y_i<GRID_H; coordinates are sampled in this cycle.
  - Out-of-range cells are dropped and oob pulses.
  - Duplicate or already-set cells are simply OR-ed in.
  - Next: SCAN with row=GRID_H-1 and a clear count of 0.
- SCAN (1 cycle per visit):
  - board[row] all ones → clear count +1, ptr=row, go to SHIFT.
  - Otherwise, row==0 → DONE.
  - Otherwise, row−1 and stay in SCAN.
- SHIFT (1 cycle per row):
  - ptr>0: board[ptr] ← board[ptr-1], then ptr−1.
  - ptr==0: board[0] ← 0, then return to SCAN at the same row, which is re-examined.
- DONE (1 cycle):
  - Pulse lock_done.
  - lines_cleared ← clear count.
  - score += {0,1,3,5,8}[clear count], saturating.
  - game_over ← 1 if board[0] is nonzero.
  - Next: IDLE.
- Collision flags are computed from the current board for cell i (each flag is the OR over all four cells):
  - collide_down: y_i≥GRID_H-1, or board[y_i+1][x_i]=1.
  - collide_left: x_i==0, or board[y_i][x_i-1]=1.
  - collide_right: x_i≥GRID_W-1, or board[y_i][x_i+1]=1.
  - A cell with y_i≥GRID_H is treated as colliding.
- Read port: rd_cell ← board[rd_row][rd_col], registered. rd_row≥GRID_H or rd_col≥GRID_W returns 0.
- game_over does not block lock_req; the mover gates on it.

## Timing
- With no clears, lock_done rises exactly 22 cycles after the edge that accepts lock_req: 1 LOCK + 20 SCAN + 1 DONE.
- Each cleared row r adds r+2 cycles: 1 detecting SCAN plus r+1 SHIFT cycles.
- Worst case is 4 clears at rows 19..16, re-scanned at row 19: 22 + 4×21 = 106 cycles.
- busy rises the cycle after acceptance and falls with lock_done.
- lines_cleared and score become valid in the same cycle as lock_done.
- Collision flags reflect board state after the last Clk edge; they are stale while busy, and the mover must not sample them then.
- Reset or new_game mid-sequence aborts to IDLE without a lock_done pulse.

## Structure
- tetris_pkg holds:
  - GRID_W and GRID_H.
  - The state enum {IDLE, LOCK, SCAN, SHIFT, DONE}.
  - The score table constant.
  - The grid-to-pixel constants (20 px cells, offsets 111/21) shared with the renderer.
- Sub-module board_collide is purely combinational: four coordinate pairs plus the board in, three collision flags out.
- The FSM, storage and read port stay in playfield_board.

## Test plan
- **Reset:** pulse Reset_n=0, then read all 200 cells → every rd_cell=0, score=0, game_over=0.
- **Lock, no clear:** lock an O piece at (4,18)(5,18)(4,19)(5,19) → lock_done after 22 cycles, lines_cleared=0; those 4 cells read 1; collide_down=1 for the same piece coordinates.
- **Single clear:** preload row 19 with columns 0..5 set (via locks), then lock an I piece at (6..9,19) → row 19 clears, the rows above shift down one, lines_cleared=1, score+=1, latency 22+21=43 cycles.
- **Tetris:** rows 16..19 each full except column 9, then lock a vertical I at (9,16..19) → lines_cleared=4, score+=8, board empty, latency 106.
- **Out of range:** lock with x3=10 → oob pulses; the other three cells are written.
- **Abort and game over:** fill column 0 up to row 0 → game_over=1 at lock_done. Then new_game during a later SCAN → board cleared, game_over=0, no lock_done pulse.
